ysyx_23060025_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the IFU fetch port and the AXI4 read channel of the memory crossbar. It accepts one fetch request at a time from the IFU (`psel`/`paddr` held until `pready`) and answers hits from on-chip storage. On a miss it refills a whole line with an AXI4 INCR burst. It also supports whole-cache invalidation on `fence.i` and keeps hit/miss performance counters.

---
 rtl/ysyx_23060025_icache.sv | 250 +++++++++++++++++++++++++
 tb/tb_ysyx_23060025_icache.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache: answers IFU fetches from local lines
// and refills a whole line over an AXI4 INCR read burst on a miss.
module ysyx_23060025_icache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_psel,
   input  logic [ADDR_WIDTH-1:0] in_paddr,
   output logic                  in_pready,
   output logic [DATA_WIDTH-1:0] in_prdata,
   input  logic                  fence_i_i,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   input  logic                  rlast,
   output logic                  rready,
   output logic                  icache_err_o,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);
   localparam int OB = $clog2(LINE_WORDS * 4);
   localparam int IB = $clog2(NUM_LINES);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int TW = ADDR_WIDTH - OB - IB;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_AR    = 3'd2,
      S_R     = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [ADDR_WIDTH-1:2]   r_addr;
   logic [NUM_LINES-1:0]    r_valid;
   logic [TW-1:0]           r_tag  [NUM_LINES];
   logic [DATA_WIDTH-1:0]   r_data [NUM_LINES*LINE_WORDS];
   logic [WB-1:0]           r_beat;
   logic                    r_err;
   logic                    r_flush_pend;
   logic [31:0]             r_hit_cnt;
   logic [31:0]             r_miss_cnt;

   logic [TW-1:0]           w_tag;
   logic [IB-1:0]           w_idx;
   logic [WB-1:0]           w_word;
   logic                    w_hit;
   logic [DATA_WIDTH-1:0]   w_rd_word;
   logic                    w_unused_paddr;

   logic                    w_pready;
   logic [DATA_WIDTH-1:0]   w_prdata;
   logic                    w_arvalid;
   logic [ADDR_WIDTH-1:0]   w_araddr;
   logic                    w_rready;
   logic                    w_err_pulse;
   logic                    w_flush;
   logic                    w_latch;
   logic                    w_hit_inc;
   logic                    w_miss_inc;
   logic                    w_ar_done;
   logic                    w_beat_wr;
   logic                    w_install;

   assign w_tag          = r_addr[ADDR_WIDTH-1:OB+IB];
   assign w_idx          = r_addr[OB+IB-1:OB];
   assign w_word         = r_addr[OB-1:2];
   assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_rd_word      = r_data[{w_idx, w_word}];
   assign w_unused_paddr = ^in_paddr[1:0];

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and per-state control strobes
   always_comb begin
      w_next      = r_state;
      w_pready    = 1'b0;
      w_prdata    = {DATA_WIDTH{1'b0}};
      w_arvalid   = 1'b0;
      w_araddr    = {ADDR_WIDTH{1'b0}};
      w_rready    = 1'b0;
      w_err_pulse = 1'b0;
      w_flush     = 1'b0;
      w_latch     = 1'b0;
      w_hit_inc   = 1'b0;
      w_miss_inc  = 1'b0;
      w_ar_done   = 1'b0;
      w_beat_wr   = 1'b0;
      w_install   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A pending or fresh flush takes priority over a new fetch
            if (r_flush_pend || fence_i_i) begin
               w_flush = 1'b1;
            end else if (in_psel) begin
               w_latch = 1'b1;
               w_next  = S_CHECK;
            end else begin
               w_next  = S_IDLE;
            end
         end
         S_CHECK: begin
            if (w_hit) begin
               w_pready  = 1'b1;
               w_prdata  = w_rd_word;
               w_hit_inc = 1'b1;
               w_next    = S_IDLE;
            end else begin
               w_miss_inc = 1'b1;
               w_next     = S_AR;
            end
         end
         S_AR: begin
            w_arvalid = 1'b1;
            w_araddr  = {r_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
            if (arready) begin
               w_ar_done = 1'b1;
               w_next    = S_R;
            end else begin
               w_next    = S_AR;
            end
         end
         S_R: begin
            w_rready = 1'b1;
            if (rvalid) begin
               w_beat_wr = 1'b1;
               w_next    = rlast ? S_RESP : S_R;
            end else begin
               w_next    = S_R;
            end
         end
         S_RESP: begin
            w_install   = !r_err;
            w_err_pulse = r_err;
            w_next      = S_IDLE;
            if (in_psel) begin
               w_pready = 1'b1;
               w_prdata = w_rd_word;
            end else begin
               w_pready = 1'b0;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Latched fetch address
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr <= {(ADDR_WIDTH-2){1'b0}};
      end else if (w_latch) begin
         r_addr <= in_paddr[ADDR_WIDTH-1:2];
      end
   end

   // Flush requests seen while busy are held until the next IDLE cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_flush_pend <= 1'b0;
      end else if (w_flush) begin
         r_flush_pend <= 1'b0;
      end else if (fence_i_i) begin
         r_flush_pend <= 1'b1;
      end
   end

   // Line valid bits
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= {NUM_LINES{1'b0}};
      end else if (w_flush) begin
         r_valid <= {NUM_LINES{1'b0}};
      end else if (w_install) begin
         r_valid[w_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them
   always_ff @(posedge clock) begin
      if (w_install) begin
         r_tag[w_idx] <= w_tag;
      end
      if (w_beat_wr) begin
         r_data[{w_idx, r_beat}] <= rdata;
      end
   end

   // Refill beat counter and sticky response error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_beat <= {WB{1'b0}};
         r_err  <= 1'b0;
      end else if (w_ar_done) begin
         r_beat <= {WB{1'b0}};
         r_err  <= 1'b0;
      end else if (w_beat_wr) begin
         r_beat <= r_beat + WB'(1'b1);
         r_err  <= r_err | (rresp != 2'b00);
      end
   end

   // Performance counters, wrapping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_hit_inc) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_miss_inc) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign in_pready    = w_pready;
   assign in_prdata    = w_prdata;
   assign arvalid      = w_arvalid;
   assign araddr       = w_araddr;
   assign rready       = w_rready;
   assign icache_err_o = w_err_pulse;
   assign arlen        = 8'(LINE_WORDS - 1);
   assign arsize       = 3'b010;
   assign arburst      = 2'b01;
   assign hit_cnt_o    = r_hit_cnt;
   assign miss_cnt_o   = r_miss_cnt;

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed bench for the instruction cache: acts as IFU and as AXI read slave,
// inputs driven and outputs sampled on the falling clock edge.
module tb_ysyx_23060025_icache;
   logic        clock;
   logic        reset;
   logic        in_psel;
   logic [31:0] in_paddr;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        fence_i_i;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rlast;
   logic        rready;
   logic        icache_err_o;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] bv [4];
   int          lat;
   logic [31:0] data;
   int          ar_cycles;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic        ar_stable;
   int          err_cnt;

   ysyx_23060025_icache dut (
      .clock(clock), .reset(reset),
      .in_psel(in_psel), .in_paddr(in_paddr), .in_pready(in_pready), .in_prdata(in_prdata),
      .fence_i_i(fence_i_i),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
      .icache_err_o(icache_err_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One fetch: raise psel, serve AR/R as a slave, record what was observed.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] beats [4],
                        input int ar_wait, input int err_beat, input int fence_beat,
                        input bit fence_start);
      int  beat;
      bit  done;
      beat = 0; done = 0;
      lat = -1; data = 32'h0; ar_cycles = 0; ar_addr = 32'h0; ar_len = 8'h0;
      ar_stable = 1'b1; err_cnt = 0;
      @(negedge clock);
      in_psel = 1'b1; in_paddr = addr;
      fence_i_i = fence_start;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(negedge clock);
         fence_i_i = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
         if (icache_err_o) err_cnt++;
         if (in_pready) begin
            lat = c; data = in_prdata; done = 1; in_psel = 1'b0;
         end
         if (arvalid) begin
            if (ar_cycles == 0) begin
               ar_addr = araddr; ar_len = arlen;
            end else if (araddr !== ar_addr) begin
               ar_stable = 1'b0;
            end
            ar_cycles++;
            if (ar_cycles > ar_wait) arready = 1'b1;
         end
         if (rready && beat < 4) begin
            rvalid = 1'b1; rdata = beats[beat]; rlast = (beat == 3);
            rresp = (beat == err_beat) ? 2'b10 : 2'b00;
            if (beat == fence_beat) fence_i_i = 1'b1;
            beat++;
         end
      end
      in_psel = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; fence_i_i = 1'b0;
   endtask

   task automatic test_reset();
      checks += 6;
      if (in_pready !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
         errors++; $display("FAIL reset_ctl: pready=%b arvalid=%b rready=%b expected 0 0 0", in_pready, arvalid, rready);
      end
      if (icache_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", icache_err_o); end
      if (in_prdata !== 32'h0 || araddr !== 32'h0) begin
         errors++; $display("FAIL reset_data: prdata=%h araddr=%h expected 0 0", in_prdata, araddr);
      end
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
         errors++; $display("FAIL reset_cnt: hit=%0d miss=%0d expected 0 0", hit_cnt_o, miss_cnt_o);
      end
      if (arlen !== 8'd3 || arsize !== 3'b010 || arburst !== 2'b01) begin
         errors++; $display("FAIL ar_const: len=%h size=%b burst=%b expected 03 010 01", arlen, arsize, arburst);
      end
      if (dut.r_valid !== 16'h0) begin errors++; $display("FAIL reset_valid: got %h expected 0000", dut.r_valid); end
   endtask

   task automatic test_cold_miss();
      bv = '{32'h11, 32'h22, 32'h33, 32'h44};
      fetch(32'h8000_0000, bv, 0, -1, -1, 1'b0);
      checks += 5;
      if (ar_addr !== 32'h8000_0000) begin errors++; $display("FAIL cold_araddr: got %h expected 80000000", ar_addr); end
      if (ar_len !== 8'd3) begin errors++; $display("FAIL cold_arlen: got %h expected 03", ar_len); end
      if (lat !== 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", lat); end
      if (data !== 32'h11) begin errors++; $display("FAIL cold_data: got %h expected 00000011", data); end
      if (miss_cnt_o !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt_o); end
   endtask

   task automatic test_hit();
      bv = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
      fetch(32'h8000_0008, bv, 0, -1, -1, 1'b0);
      @(negedge clock);
      checks += 4;
      if (lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", lat); end
      if (data !== 32'h33) begin errors++; $display("FAIL hit_data: got %h expected 00000033", data); end
      if (ar_cycles !== 0) begin errors++; $display("FAIL hit_no_ar: got %0d AR cycles expected 0", ar_cycles); end
      if (hit_cnt_o !== 32'd1) begin errors++; $display("FAIL hit_cnt: got %0d expected 1", hit_cnt_o); end
   endtask

   task automatic test_conflict();
      bv = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      fetch(32'h8000_0100, bv, 0, -1, -1, 1'b0);
      checks += 3;
      if (ar_addr !== 32'h8000_0100) begin errors++; $display("FAIL conf_araddr: got %h expected 80000100", ar_addr); end
      if (lat !== 7) begin errors++; $display("FAIL conf_latency: got %0d expected 7", lat); end
      if (data !== 32'hA1) begin errors++; $display("FAIL conf_data: got %h expected 000000a1", data); end
      bv = '{32'h11, 32'h22, 32'h33, 32'h44};
      fetch(32'h8000_0000, bv, 0, -1, -1, 1'b0);
      checks += 3;
      if (lat !== 7) begin errors++; $display("FAIL refetch_latency: got %0d expected 7", lat); end
      if (data !== 32'h11) begin errors++; $display("FAIL refetch_data: got %h expected 00000011", data); end
      if (miss_cnt_o !== 32'd3) begin errors++; $display("FAIL conf_miss_cnt: got %0d expected 3", miss_cnt_o); end
   endtask

   task automatic test_back_to_back();
      fetch(32'h8000_000C, bv, 0, -1, -1, 1'b0);
      @(negedge clock);
      checks += 3;
      if (lat !== 1) begin errors++; $display("FAIL b2b_latency: got %0d expected 1", lat); end
      if (data !== 32'h44) begin errors++; $display("FAIL b2b_data: got %h expected 00000044", data); end
      if (hit_cnt_o !== 32'd2) begin errors++; $display("FAIL b2b_hit_cnt: got %0d expected 2", hit_cnt_o); end
   endtask

   task automatic test_fence();
      bv = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
      fetch(32'h8000_0010, bv, 0, -1, 1, 1'b0);
      checks += 2;
      if (lat !== 7) begin errors++; $display("FAIL fence_refill_latency: got %0d expected 7", lat); end
      if (data !== 32'hB1) begin errors++; $display("FAIL fence_refill_data: got %h expected 000000b1", data); end
      // Pending flush is applied in the first IDLE cycle, delaying the next request by one
      bv = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
      fetch(32'h8000_0010, bv, 0, -1, -1, 1'b0);
      checks += 3;
      if (lat !== 8) begin errors++; $display("FAIL fence_refetch_latency: got %0d expected 8", lat); end
      if (data !== 32'hC1) begin errors++; $display("FAIL fence_refetch_data: got %h expected 000000c1", data); end
      if (miss_cnt_o !== 32'd5) begin errors++; $display("FAIL fence_miss_cnt: got %0d expected 5", miss_cnt_o); end
      bv = '{32'h11, 32'h22, 32'h33, 32'h44};
      fetch(32'h8000_0000, bv, 0, -1, -1, 1'b0);
      checks += 1;
      if (lat !== 7) begin errors++; $display("FAIL fence_other_line: got latency %0d expected 7", lat); end
      fetch(32'h8000_0004, bv, 0, -1, -1, 1'b1);
      checks += 3;
      if (lat !== 8) begin errors++; $display("FAIL fence_idle_latency: got %0d expected 8", lat); end
      if (data !== 32'h22) begin errors++; $display("FAIL fence_idle_data: got %h expected 00000022", data); end
      if (miss_cnt_o !== 32'd7 || hit_cnt_o !== 32'd2) begin
         errors++; $display("FAIL fence_counts: hit=%0d miss=%0d expected 2 7", hit_cnt_o, miss_cnt_o);
      end
   endtask

   task automatic test_ar_stall_error();
      bv = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
      fetch(32'h8000_0020, bv, 5, 1, -1, 1'b0);
      checks += 6;
      if (ar_cycles !== 6) begin errors++; $display("FAIL stall_ar_cycles: got %0d expected 6", ar_cycles); end
      if (ar_stable !== 1'b1 || ar_addr !== 32'h8000_0020) begin
         errors++; $display("FAIL stall_araddr: got %h stable=%b expected 80000020 1", ar_addr, ar_stable);
      end
      if (lat !== 12) begin errors++; $display("FAIL stall_latency: got %0d expected 12", lat); end
      if (err_cnt !== 1) begin errors++; $display("FAIL err_pulse: got %0d pulses expected 1", err_cnt); end
      if (data !== 32'hD1) begin errors++; $display("FAIL err_data: got %h expected 000000d1", data); end
      if (miss_cnt_o !== 32'd8) begin errors++; $display("FAIL err_miss_cnt: got %0d expected 8", miss_cnt_o); end
      bv = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
      fetch(32'h8000_0024, bv, 0, -1, -1, 1'b0);
      checks += 3;
      if (lat !== 7) begin errors++; $display("FAIL err_refetch_latency: got %0d expected 7", lat); end
      if (data !== 32'hE2) begin errors++; $display("FAIL err_refetch_data: got %h expected 000000e2", data); end
      if (err_cnt !== 0) begin errors++; $display("FAIL err_clean: got %0d pulses expected 0", err_cnt); end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clock); in_psel = 1'b1; in_paddr = 32'h8000_0030;
      @(negedge clock);
      @(negedge clock); arready = 1'b1;
      @(negedge clock); arready = 1'b0;
      checks += 1;
      if (rready !== 1'b1) begin errors++; $display("FAIL mid_rready: got %b expected 1", rready); end
      rvalid = 1'b1; rdata = 32'hF0; rresp = 2'b00; rlast = 1'b0;
      @(negedge clock); rdata = 32'hF1;
      #2 reset = 1'b1;
      #1;
      checks += 2;
      if (arvalid !== 1'b0 || rready !== 1'b0 || in_pready !== 1'b0) begin
         errors++; $display("FAIL mid_reset_ctl: arvalid=%b rready=%b pready=%b expected 0 0 0", arvalid, rready, in_pready);
      end
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
         errors++; $display("FAIL mid_reset_cnt: hit=%0d miss=%0d expected 0 0", hit_cnt_o, miss_cnt_o);
      end
      in_psel = 1'b0; rvalid = 1'b0;
      @(negedge clock); reset = 1'b0;
      bv = '{32'h51, 32'h52, 32'h53, 32'h54};
      fetch(32'h8000_0030, bv, 0, -1, -1, 1'b0);
      checks += 2;
      if (lat !== 7 || data !== 32'h51) begin
         errors++; $display("FAIL post_reset_fetch: latency=%0d data=%h expected 7 00000051", lat, data);
      end
      if (miss_cnt_o !== 32'd1) begin errors++; $display("FAIL post_reset_miss_cnt: got %0d expected 1", miss_cnt_o); end
      bv = '{32'h11, 32'h22, 32'h33, 32'h44};
      fetch(32'h8000_0000, bv, 0, -1, -1, 1'b0);
      checks += 1;
      if (lat !== 7) begin errors++; $display("FAIL post_reset_invalid: got latency %0d expected 7", lat); end
   endtask

   initial begin
      reset = 1'b1; in_psel = 1'b0; in_paddr = 32'h0; fence_i_i = 1'b0;
      arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0; rlast = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      reset = 1'b0;
      test_cold_miss();
      test_hit();
      test_conflict();
      test_back_to_back();
      test_fence();
      test_ar_stall_error();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
